// File: rtl/otter_rvfi_nret.sv
// otter_rvfi_nret: packs retirement records into NRET-slot RVFI groups behind a DEPTH-entry FIFO
// Ports: i_clk/i_rst (async active-high); i_valid/o_ready record handshake with i_trap, i_excp and
// record fields; o_grp_valid/i_trace_ready sink handshake; rvfi_* packed slot outputs (slot k at [k*W +: W]);
// o_drop_count counts discarded records.
// Build option: OTTER_RVFI_DROP_EN discards groups that find the FIFO full instead of stalling the core.
module otter_rvfi_nret #(
    parameter int XLEN         = 32,
    parameter int NRET         = 2,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_trap,
    input  logic                   i_excp,
    input  logic [31:0]            i_insn,
    input  logic [XLEN-1:0]        i_pc_rdata,
    input  logic [XLEN-1:0]        i_pc_wdata,
    input  logic [4:0]             i_rd_addr,
    input  logic [XLEN-1:0]        i_rd_wdata,
    input  logic [4:0]             i_rs1_addr,
    input  logic [4:0]             i_rs2_addr,
    input  logic [XLEN-1:0]        i_rs1_rdata,
    input  logic [XLEN-1:0]        i_rs2_rdata,
    input  logic [XLEN-1:0]        i_mem_addr,
    input  logic [XLEN/8-1:0]      i_mem_rmask,
    input  logic [XLEN/8-1:0]      i_mem_wmask,
    input  logic [XLEN-1:0]        i_mem_rdata,
    input  logic [XLEN-1:0]        i_mem_wdata,
    output logic                   o_grp_valid,
    input  logic                   i_trace_ready,
    output logic [NRET-1:0]        rvfi_valid,
    output logic [64*NRET-1:0]     rvfi_order,
    output logic [32*NRET-1:0]     rvfi_insn,
    output logic [NRET-1:0]        rvfi_trap,
    output logic [NRET-1:0]        rvfi_intr,
    output logic [XLEN*NRET-1:0]   rvfi_pc_rdata,
    output logic [XLEN*NRET-1:0]   rvfi_pc_wdata,
    output logic [5*NRET-1:0]      rvfi_rd_addr,
    output logic [XLEN*NRET-1:0]   rvfi_rd_wdata,
    output logic [5*NRET-1:0]      rvfi_rs1_addr,
    output logic [5*NRET-1:0]      rvfi_rs2_addr,
    output logic [XLEN*NRET-1:0]   rvfi_rs1_rdata,
    output logic [XLEN*NRET-1:0]   rvfi_rs2_rdata,
    output logic [XLEN*NRET-1:0]   rvfi_mem_addr,
    output logic [XLEN/8*NRET-1:0] rvfi_mem_rmask,
    output logic [XLEN/8*NRET-1:0] rvfi_mem_wmask,
    output logic [XLEN*NRET-1:0]   rvfi_mem_rdata,
    output logic [XLEN*NRET-1:0]   rvfi_mem_wdata,
    output logic [15:0]            o_drop_count
);
    localparam int MW = XLEN / 8;
    localparam int IW = NRET > 1 ? $clog2(NRET) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic            valid;
        logic [63:0]     order;
        logic [31:0]     insn;
        logic            trap;
        logic            intr;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] mem_addr;
        logic [MW-1:0]   mem_rmask;
        logic [MW-1:0]   mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } rec_t;

    rec_t          r_stage [NRET];
    rec_t          r_fifo  [DEPTH][NRET];
    logic [IW-1:0] r_idx;
    logic [63:0]   r_order;
    logic          r_intr;
    logic [TW-1:0] r_timer;
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;

    rec_t w_rec;
    rec_t w_grp  [NRET];
    rec_t w_head [NRET];
    logic w_acc, w_pop, w_full, w_space, w_close, w_idle, w_flush, w_push, w_clear;

    assign w_full      = r_count == (AW+1)'(DEPTH);
    assign o_grp_valid = r_count != '0;
    assign w_pop       = o_grp_valid && i_trace_ready;
    // A pop in the same cycle frees the entry a closing group needs.
    assign w_space     = !w_full || w_pop;
`ifdef OTTER_RVFI_DROP_EN
    assign o_ready     = !i_rst;
`else
    assign o_ready     = !i_rst && w_space;
`endif
    assign w_acc       = i_valid && o_ready;
    assign w_close     = w_acc && (r_idx == IW'(NRET - 1) || i_trap);
    assign w_idle      = r_idx != '0 && !w_acc;
    assign w_flush     = w_idle && r_timer == TW'(FLUSH_CYCLES - 1);
    assign w_push      = (w_close || w_flush) && w_space;
`ifdef OTTER_RVFI_DROP_EN
    // Groups without space are discarded, so staging empties either way.
    assign w_clear     = w_close || w_flush;
`else
    // A blocked flush keeps its staging until the FIFO frees up.
    assign w_clear     = w_push;
`endif

    always_comb begin
        w_rec           = '0;
        w_rec.valid     = 1'b1;
        w_rec.order     = r_order;
        w_rec.insn      = i_insn;
        w_rec.trap      = i_trap;
        w_rec.intr      = r_intr;
        w_rec.pc_rdata  = i_pc_rdata;
        w_rec.pc_wdata  = i_pc_wdata;
        w_rec.rd_addr   = i_rd_addr;
        w_rec.rd_wdata  = i_rd_addr == 5'd0 ? '0 : i_rd_wdata;
        w_rec.rs1_addr  = i_rs1_addr;
        w_rec.rs2_addr  = i_rs2_addr;
        w_rec.rs1_rdata = i_rs1_rdata;
        w_rec.rs2_rdata = i_rs2_rdata;
        w_rec.mem_addr  = i_mem_addr;
        w_rec.mem_rmask = i_trap ? '0 : i_mem_rmask;
        w_rec.mem_wmask = i_trap ? '0 : i_mem_wmask;
        w_rec.mem_rdata = i_trap ? '0 : i_mem_rdata;
        w_rec.mem_wdata = i_trap ? '0 : i_mem_wdata;
    end

    // The group leaving staging includes the record accepted this cycle.
    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            w_grp[k]  = (w_acc && r_idx == IW'(k)) ? w_rec : r_stage[k];
            w_head[k] = o_grp_valid ? r_fifo[r_rp][k] : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NRET; k++) r_stage[k] <= '0;
            r_idx   <= '0;
            r_order <= '0;
            r_intr  <= 1'b0;
            r_timer <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_clear) begin
                for (int k = 0; k < NRET; k++) r_stage[k] <= '0;
                r_idx <= '0;
            end else if (w_acc) begin
                r_stage[r_idx] <= w_rec;
                r_idx          <= r_idx + 1'b1;
            end
            if (w_acc) r_order <= r_order + 64'd1;
            r_intr  <= (i_excp || (w_acc && i_trap)) ? 1'b1 : w_acc ? 1'b0 : r_intr;
            r_timer <= (w_acc || w_clear) ? '0 : (w_idle && !w_flush) ? r_timer + 1'b1 : r_timer;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) for (int k = 0; k < NRET; k++) r_fifo[r_wp][k] <= w_grp[k];
    end

`ifdef OTTER_RVFI_DROP_EN
    logic [15:0] r_drop;
    logic [16:0] w_drop_sum;
    // Valid slots in a discarded group: staged ones plus any record accepted now.
    assign w_drop_sum = {1'b0, r_drop} + 17'(r_idx) + 17'(w_acc);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_drop <= '0;
        else if ((w_close || w_flush) && !w_space) r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
    assign o_drop_count = r_drop;
`else
    assign o_drop_count = '0;
`endif

    for (genvar k = 0; k < NRET; k++) begin : g_slot
        assign rvfi_valid[k]                   = w_head[k].valid;
        assign rvfi_order[k*64 +: 64]          = w_head[k].order;
        assign rvfi_insn[k*32 +: 32]           = w_head[k].insn;
        assign rvfi_trap[k]                    = w_head[k].trap;
        assign rvfi_intr[k]                    = w_head[k].intr;
        assign rvfi_pc_rdata[k*XLEN +: XLEN]   = w_head[k].pc_rdata;
        assign rvfi_pc_wdata[k*XLEN +: XLEN]   = w_head[k].pc_wdata;
        assign rvfi_rd_addr[k*5 +: 5]          = w_head[k].rd_addr;
        assign rvfi_rd_wdata[k*XLEN +: XLEN]   = w_head[k].rd_wdata;
        assign rvfi_rs1_addr[k*5 +: 5]         = w_head[k].rs1_addr;
        assign rvfi_rs2_addr[k*5 +: 5]         = w_head[k].rs2_addr;
        assign rvfi_rs1_rdata[k*XLEN +: XLEN]  = w_head[k].rs1_rdata;
        assign rvfi_rs2_rdata[k*XLEN +: XLEN]  = w_head[k].rs2_rdata;
        assign rvfi_mem_addr[k*XLEN +: XLEN]   = w_head[k].mem_addr;
        assign rvfi_mem_rmask[k*MW +: MW]      = w_head[k].mem_rmask;
        assign rvfi_mem_wmask[k*MW +: MW]      = w_head[k].mem_wmask;
        assign rvfi_mem_rdata[k*XLEN +: XLEN]  = w_head[k].mem_rdata;
        assign rvfi_mem_wdata[k*XLEN +: XLEN]  = w_head[k].mem_wdata;
    end
endmodule

// File: tb/tb_otter_rvfi_nret.sv
// tb_otter_rvfi_nret: table, directed and randomized checks of otter_rvfi_nret against a queue-based model
module tb_otter_rvfi_nret;
    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 4;
    localparam int FLUSH = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid = 1'b0, trap = 1'b0, excp = 1'b0, tr = 1'b0, o_ready, o_grp_valid;
    logic [31:0] insn = '0, pc_rdata = '0, pc_wdata = '0, rd_wdata = '0, rs1_rdata = '0, rs2_rdata = '0;
    logic [31:0] mem_addr = '0, mem_rdata = '0, mem_wdata = '0;
    logic [4:0]  rd_addr = '0, rs1_addr = '0, rs2_addr = '0;
    logic [3:0]  mem_rmask = '0, mem_wmask = '0;
    logic [NRET-1:0]    rvfi_valid, rvfi_trap, rvfi_intr;
    logic [64*NRET-1:0] rvfi_order;
    logic [32*NRET-1:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [32*NRET-1:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [5*NRET-1:0]  rvfi_rd_addr, rvfi_rs1_addr, rvfi_rs2_addr;
    logic [4*NRET-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [15:0]        o_drop_count;

    always #5 clk = ~clk;

    otter_rvfi_nret #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_trap(trap), .i_excp(excp),
        .i_insn(insn), .i_pc_rdata(pc_rdata), .i_pc_wdata(pc_wdata), .i_rd_addr(rd_addr), .i_rd_wdata(rd_wdata),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rs1_rdata(rs1_rdata), .i_rs2_rdata(rs2_rdata),
        .i_mem_addr(mem_addr), .i_mem_rmask(mem_rmask), .i_mem_wmask(mem_wmask), .i_mem_rdata(mem_rdata),
        .i_mem_wdata(mem_wdata), .o_grp_valid(o_grp_valid), .i_trace_ready(tr),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rs1_addr(rvfi_rs1_addr),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata), .o_drop_count(o_drop_count)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [31:0] pc_rdata, pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [4:0]  rs1_addr, rs2_addr;
        logic [31:0] rs1_rdata, rs2_rdata, mem_addr;
        logic [3:0]  mem_rmask, mem_wmask;
        logic [31:0] mem_rdata, mem_wdata;
    } rec_t;
    typedef rec_t [NRET-1:0] grp_t;

    typedef struct {
        logic        v, trap, excp, tr;
        logic [4:0]  rda;
        logic [31:0] rdw;
        logic        gv;
        logic [1:0]  val;
        logic [63:0] o0, o1;
        logic [1:0]  intr, trp;
        logic [31:0] rdw0;
    } row_t;

    int n_checks = 0, n_errors = 0;

    task automatic check(string nm, logic [399:0] act, logic [399:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic rec_t slot(int k);
        rec_t r;
        r.valid = rvfi_valid[k];          r.order = rvfi_order[k*64 +: 64];
        r.insn = rvfi_insn[k*32 +: 32];   r.trap = rvfi_trap[k];  r.intr = rvfi_intr[k];
        r.pc_rdata = rvfi_pc_rdata[k*32 +: 32];   r.pc_wdata = rvfi_pc_wdata[k*32 +: 32];
        r.rd_addr = rvfi_rd_addr[k*5 +: 5];       r.rd_wdata = rvfi_rd_wdata[k*32 +: 32];
        r.rs1_addr = rvfi_rs1_addr[k*5 +: 5];     r.rs2_addr = rvfi_rs2_addr[k*5 +: 5];
        r.rs1_rdata = rvfi_rs1_rdata[k*32 +: 32]; r.rs2_rdata = rvfi_rs2_rdata[k*32 +: 32];
        r.mem_addr = rvfi_mem_addr[k*32 +: 32];
        r.mem_rmask = rvfi_mem_rmask[k*4 +: 4];   r.mem_wmask = rvfi_mem_wmask[k*4 +: 4];
        r.mem_rdata = rvfi_mem_rdata[k*32 +: 32]; r.mem_wdata = rvfi_mem_wdata[k*32 +: 32];
        return r;
    endfunction

    // Reference model: staged records and FIFO groups kept as queues, advanced once per cycle.
    rec_t        m_stage[$];
    grp_t        m_q[$];
    logic [63:0] m_order = '0;
    bit          m_intr = 1'b0, m_pop, m_space, m_rdy, m_acc, m_push;
    int          m_idle = 0, m_drop = 0;
    grp_t        m_h, m_g;
    rec_t        m_r;

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", 400'(o_ready), 400'(0));
            m_stage.delete(); m_q.delete();
            m_order = '0; m_intr = 1'b0; m_idle = 0; m_drop = 0;
        end else begin
            m_h = (m_q.size() > 0) ? m_q[0] : '0;
            check("grp_valid", 400'(o_grp_valid), 400'(m_q.size() > 0));
            for (int k = 0; k < NRET; k++) check($sformatf("slot%0d", k), 400'(slot(k)), 400'(m_h[k]));
            m_pop   = m_q.size() > 0 && tr;
            m_space = m_q.size() < DEPTH || m_pop;
`ifdef OTTER_RVFI_DROP_EN
            m_rdy = 1'b1;
`else
            m_rdy = m_space;
`endif
            check("ready", 400'(o_ready), 400'(m_rdy));
            check("drop_count", 400'(o_drop_count), 400'(m_drop));
            m_acc = valid && m_rdy;
            if (m_pop) void'(m_q.pop_front());
            m_push = 1'b0;
            if (m_acc) begin
                m_r = '{valid: 1'b1, order: m_order, insn: insn, trap: trap, intr: m_intr,
                        pc_rdata: pc_rdata, pc_wdata: pc_wdata, rd_addr: rd_addr,
                        rd_wdata: rd_addr == 5'd0 ? 32'd0 : rd_wdata, rs1_addr: rs1_addr, rs2_addr: rs2_addr,
                        rs1_rdata: rs1_rdata, rs2_rdata: rs2_rdata, mem_addr: mem_addr,
                        mem_rmask: trap ? 4'd0 : mem_rmask, mem_wmask: trap ? 4'd0 : mem_wmask,
                        mem_rdata: trap ? 32'd0 : mem_rdata, mem_wdata: trap ? 32'd0 : mem_wdata};
                m_order = m_order + 64'd1;
                m_stage.push_back(m_r);
                m_idle = 0;
                m_push = m_stage.size() == NRET || trap;
            end else if (m_stage.size() > 0) begin
                m_idle++;
                m_push = m_idle >= FLUSH;
            end
            if (m_push && m_space) begin
                m_g = '0;
                for (int i = 0; i < m_stage.size(); i++) m_g[i] = m_stage[i];
                m_q.push_back(m_g);
                m_stage.delete(); m_idle = 0;
            end
`ifdef OTTER_RVFI_DROP_EN
            else if (m_push) begin
                m_drop = (m_drop + m_stage.size() > 65535) ? 65535 : m_drop + m_stage.size();
                m_stage.delete(); m_idle = 0;
            end
`endif
            if (excp || (m_acc && trap)) m_intr = 1'b1;
            else if (m_acc) m_intr = 1'b0;
        end
    end

    task automatic rnd_fields();
        insn = $urandom; pc_rdata = $urandom; pc_wdata = $urandom;
        rs1_addr = 5'($urandom); rs2_addr = 5'($urandom); rs1_rdata = $urandom; rs2_rdata = $urandom;
        mem_addr = $urandom; mem_rmask = 4'($urandom); mem_wmask = 4'($urandom);
        mem_rdata = $urandom; mem_wdata = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t mkrow(logic v, trap, excp, tr, logic [4:0] rda, logic [31:0] rdw, logic gv,
                                   logic [1:0] val, logic [63:0] o0, o1, logic [1:0] intr, trp, logic [31:0] rdw0);
        row_t r;
        r.v = v; r.trap = trap; r.excp = excp; r.tr = tr; r.rda = rda; r.rdw = rdw;
        r.gv = gv; r.val = val; r.o0 = o0; r.o1 = o1; r.intr = intr; r.trp = trp; r.rdw0 = rdw0;
        return r;
    endfunction

    row_t tbl[$];

    task automatic add_idle(int n);
        for (int i = 0; i < n; i++)
            tbl.push_back(mkrow(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 2'd0, 32'd0));
    endtask

    task automatic add_rec(logic tp, logic [4:0] rda, logic [31:0] rdw);
        tbl.push_back(mkrow(1'b1, tp, 1'b0, 1'b1, rda, rdw, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 2'd0, 32'd0));
    endtask

    initial begin
        int n, g;
        bit found;
        // Back-to-back pairs, flush of a lone record, then intr/trap grouping.
        add_rec(1'b0, 5'd3, 32'h1000);
        add_rec(1'b0, 5'd3, 32'h1001);
        tbl.push_back(mkrow(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1002, 1'b1, 2'b11, 64'd0, 64'd1, 2'b00, 2'b00, 32'h1000));
        add_rec(1'b0, 5'd3, 32'h1003);
        tbl.push_back(mkrow(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 1'b1, 2'b11, 64'd2, 64'd3, 2'b00, 2'b00, 32'h1002));
        add_idle(1);
        add_rec(1'b0, 5'd0, 32'hDEAD);
        add_idle(8);
        tbl.push_back(mkrow(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 1'b1, 2'b01, 64'd4, 64'd0, 2'b00, 2'b00, 32'd0));
        add_rec(1'b0, 5'd3, 32'h1010);
        tbl.push_back(mkrow(1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'd0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 2'd0, 32'd0));
        add_rec(1'b1, 5'd3, 32'h1012);
        tbl.push_back(mkrow(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1013, 1'b1, 2'b11, 64'd5, 64'd6, 2'b10, 2'b10, 32'h1010));
        add_idle(8);
        tbl.push_back(mkrow(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 1'b1, 2'b01, 64'd7, 64'd0, 2'b01, 2'b00, 32'h1013));
        add_idle(1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_grp_valid", 400'(o_grp_valid), 400'(0));
        check("rst_rvfi_valid", 400'(rvfi_valid), 400'(0));
        check("rst_rvfi_order", 400'(rvfi_order), 400'(0));
        check("rst_drop", 400'(o_drop_count), 400'(0));
        step();
        rst = 1'b0;

        foreach (tbl[i]) begin
            valid = tbl[i].v; trap = tbl[i].trap; excp = tbl[i].excp; tr = tbl[i].tr;
            rd_addr = tbl[i].rda; rd_wdata = tbl[i].rdw;
            rnd_fields();
            @(negedge clk);
            check($sformatf("tbl%0d_gv", i), 400'(o_grp_valid), 400'(tbl[i].gv));
            check($sformatf("tbl%0d_valid", i), 400'(rvfi_valid), 400'(tbl[i].val));
            check($sformatf("tbl%0d_order0", i), 400'(rvfi_order[63:0]), 400'(tbl[i].o0));
            check($sformatf("tbl%0d_order1", i), 400'(rvfi_order[127:64]), 400'(tbl[i].o1));
            check($sformatf("tbl%0d_intr", i), 400'(rvfi_intr), 400'(tbl[i].intr));
            check($sformatf("tbl%0d_trap", i), 400'(rvfi_trap), 400'(tbl[i].trp));
            check($sformatf("tbl%0d_rdw0", i), 400'(rvfi_rd_wdata[31:0]), 400'(tbl[i].rdw0));
            step();
        end
        excp = 1'b0; trap = 1'b0; rd_addr = 5'd1;

`ifndef OTTER_RVFI_DROP_EN
        // Backpressure: four groups fill the FIFO, then the sink drains them in order.
        tr = 1'b0; valid = 1'b1; n = 0;
        repeat (10) begin
            rnd_fields();
            @(negedge clk);
            if (o_ready) n++;
            step();
        end
        check("bp_accepted", 400'(n), 400'(8));
        valid = 1'b0;
        @(negedge clk);
        check("bp_ready_low", 400'(o_ready), 400'(0));
        step();
        tr = 1'b1; g = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_grp_valid) begin
                check($sformatf("bp_order0_g%0d", g), 400'(rvfi_order[63:0]), 400'(8 + 2 * g));
                check($sformatf("bp_order1_g%0d", g), 400'(rvfi_order[127:64]), 400'(9 + 2 * g));
                g++;
            end
            step();
        end
        check("bp_groups", 400'(g), 400'(4));
`else
        // Drop mode: the fifth group finds the FIFO full and is discarded.
        rst = 1'b1;
        step();
        rst = 1'b0; tr = 1'b0; valid = 1'b1;
        repeat (10) begin
            rnd_fields();
            step();
        end
        valid = 1'b0;
        @(negedge clk);
        check("drop_count_2", 400'(o_drop_count), 400'(2));
        step();
        tr = 1'b1; g = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_grp_valid) begin
                check($sformatf("drop_kept_g%0d", g), 400'(rvfi_order[63:0]), 400'(2 * g));
                g++;
            end
            step();
        end
        check("drop_groups", 400'(g), 400'(4));
        valid = 1'b1;
        repeat (2) begin
            rnd_fields();
            step();
        end
        valid = 1'b0; found = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_grp_valid && !found) begin
                check("drop_next_order", 400'(rvfi_order[63:0]), 400'(10));
                found = 1'b1;
            end
            step();
        end
        check("drop_next_seen", 400'(found), 400'(1));
`endif

        // Mid-stream reset with two groups buffered.
        tr = 1'b0; valid = 1'b1;
        repeat (4) begin
            rnd_fields();
            step();
        end
        valid = 1'b0;
        @(negedge clk);
        check("mid_half_full", 400'(o_grp_valid), 400'(1));
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_gv", 400'(o_grp_valid), 400'(0));
        check("mid_rst_valid", 400'(rvfi_valid), 400'(0));
        step();
        rst = 1'b0; tr = 1'b1; valid = 1'b1;
        repeat (2) begin
            rnd_fields();
            step();
        end
        valid = 1'b0; found = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_grp_valid && !found) begin
                check("mid_first_order", 400'(rvfi_order[63:0]), 400'(0));
                found = 1'b1;
            end
            step();
        end
        check("mid_first_seen", 400'(found), 400'(1));

        // Randomized traffic alternating busy and sparse phases so flushes and backpressure both occur.
        for (int i = 0; i < 3000; i++) begin
            valid = $urandom_range(0, 99) < (((i / 64) % 2) != 0 ? 5 : 70);
            trap = $urandom_range(0, 9) == 0;
            excp = $urandom_range(0, 19) == 0;
            tr = $urandom_range(0, 99) < 60;
            rd_addr = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            rd_wdata = $urandom;
            rnd_fields();
            step();
        end
        valid = 1'b0; trap = 1'b0; excp = 1'b0; tr = 1'b1;
        repeat (20) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
